// File: rtl/rx_operand_collector_if.sv
// Byte-stream and operand-set bundle between the UART receiver, the collector and the ALU.
// The slave modport is the collector's view; the master modport is the receiver/ALU side.
interface rx_operand_collector_if #(
    parameter int DBIT  = 8,
    parameter int NB_OP = 6
);
    logic [DBIT-1:0]  i_data;
    logic             i_done_data;
    logic [DBIT-1:0]  o_a;
    logic [DBIT-1:0]  o_b;
    logic [NB_OP-1:0] o_op;
    logic             o_rx_alu_done;
    logic             o_timeout;

    modport master (
        output i_data, i_done_data,
        input  o_a, o_b, o_op, o_rx_alu_done, o_timeout
    );

    modport slave (
        input  i_data, i_done_data,
        output o_a, o_b, o_op, o_rx_alu_done, o_timeout
    );
endinterface

// File: rtl/rx_operand_collector.sv
// Assembles three received bytes (A, B, opcode) into a coherent ALU operand set.
// Define RX_TIMEOUT_EN to drop partial frames after TIMEOUT_CYC idle cycles.
module rx_operand_collector #(
    parameter int DBIT        = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    rx_operand_collector_if.slave   io_bus
);

    typedef enum logic [1:0] {
        S_A  = 2'd0,
        S_B  = 2'd1,
        S_OP = 2'd2
    } state_t;

    state_t           r_state;
    logic [DBIT-1:0]  r_stage_a;
    logic [DBIT-1:0]  r_stage_b;
    logic [DBIT-1:0]  r_a;
    logic [DBIT-1:0]  r_b;
    logic [NB_OP-1:0] r_op;
    logic             r_done;
    logic             w_expire;

`ifdef RX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // A strobe in the expiry cycle wins, so expiry requires an idle cycle.
    assign w_expire = (r_state != S_A) && !io_bus.i_done_data &&
                      (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == S_A || io_bus.i_done_data || w_expire)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign io_bus.o_timeout = r_timeout;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign w_expire         = 1'b0;
    assign io_bus.o_timeout = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking would let r_a see the new stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_A;
            r_stage_a <= '0;
            r_stage_b <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (io_bus.i_done_data) begin
                case (r_state)
                    S_A: begin
                        r_stage_a <= io_bus.i_data;
                        r_state   <= S_B;
                    end
                    S_B: begin
                        r_stage_b <= io_bus.i_data;
                        r_state   <= S_OP;
                    end
                    S_OP: begin
                        r_a     <= r_stage_a;
                        r_b     <= r_stage_b;
                        r_op    <= io_bus.i_data[NB_OP-1:0];
                        r_done  <= 1'b1;
                        r_state <= S_A;
                    end
                    default: r_state <= S_A;
                endcase
            end else if (w_expire) begin
                // Drop the partial frame; the published operand set is untouched.
                r_state   <= S_A;
                r_stage_a <= '0;
                r_stage_b <= '0;
            end
        end
    end

    assign io_bus.o_a           = r_a;
    assign io_bus.o_b           = r_b;
    assign io_bus.o_op          = r_op;
    assign io_bus.o_rx_alu_done = r_done;

endmodule

// File: tb/tb_rx_operand_collector.sv
// Directed bench for rx_operand_collector: reset, framing, truncation, hold, mid-frame reset
// and the inter-byte timeout (timeout checks depend on RX_TIMEOUT_EN).
module tb_rx_operand_collector;

    localparam int DBIT  = 8;
    localparam int NB_OP = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_tmo = 0;

    rx_operand_collector_if #(.DBIT(DBIT), .NB_OP(NB_OP)) bus ();

    rx_operand_collector #(
        .DBIT        (DBIT),
        .NB_OP       (NB_OP),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Counts timeout pulses observed in the cycle before each rising edge.
    always @(posedge clk) if (bus.o_timeout === 1'b1) n_tmo++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [5:0] op, input logic done);
        check({tag, ".a"},    32'(bus.o_a), 32'(a));
        check({tag, ".b"},    32'(bus.o_b), 32'(b));
        check({tag, ".op"},   32'(bus.o_op), 32'(op));
        check({tag, ".done"}, 32'(bus.o_rx_alu_done), 32'(done));
        check({tag, ".tmo"},  32'(bus.o_timeout), 32'd0);
    endtask

    // Called at a falling edge; presents one byte for exactly one rising edge.
    task automatic strobe(input logic [7:0] b);
        bus.i_done_data = 1'b1;
        bus.i_data      = b;
        @(negedge clk);
        bus.i_done_data = 1'b0;
        bus.i_data      = 8'h5A;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int tmo_base;
        bus.i_done_data = 1'b0;
        bus.i_data      = 8'h00;

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_out("reset", 8'h00, 8'h00, 6'h00, 1'b0);

        // Basic frame with strobes 10 cycles apart.
        strobe(8'h05);
        idle(9);
        strobe(8'h03);
        check_out("basic_partial", 8'h00, 8'h00, 6'h00, 1'b0);
        idle(9);
        strobe(8'h20);
        check_out("basic", 8'h05, 8'h03, 6'h20, 1'b1);
        @(negedge clk);
        check("basic_pulse_end", 32'(bus.o_rx_alu_done), 32'd0);

        // Back-to-back strobes, opcode truncated to its low 6 bits.
        strobe(8'hFF);
        strobe(8'h80);
        strobe(8'hE6);
        check_out("trunc", 8'hFF, 8'h80, 6'h26, 1'b1);
        @(negedge clk);
        check_out("trunc_hold", 8'hFF, 8'h80, 6'h26, 1'b0);

        // Output hold across a partial frame.
        strobe(8'h11);
        strobe(8'h22);
        strobe(8'h03);
        check_out("hold_frame", 8'h11, 8'h22, 6'h03, 1'b1);
        strobe(8'hAA);
        check_out("hold_aa", 8'h11, 8'h22, 6'h03, 1'b0);
        strobe(8'hBB);
        check_out("hold_bb", 8'h11, 8'h22, 6'h03, 1'b0);

        // Mid-frame reset drops the AA/BB partial frame.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_out("midreset", 8'h00, 8'h00, 6'h00, 1'b0);
        strobe(8'h01);
        check("midreset_no_early_done", 32'(bus.o_rx_alu_done), 32'd0);
        strobe(8'h02);
        check("midreset_no_done_b", 32'(bus.o_rx_alu_done), 32'd0);
        strobe(8'h04);
        check_out("after_reset", 8'h01, 8'h02, 6'h04, 1'b1);
        @(negedge clk);
        check("after_reset_pulse_end", 32'(bus.o_rx_alu_done), 32'd0);

`ifdef RX_TIMEOUT_EN
        // Partial frame abandoned after 16 idle cycles.
        tmo_base = n_tmo;
        strobe(8'h0A);
        idle(20);
        check("tmo_pulses", 32'(n_tmo - tmo_base), 32'd1);
        check_out("tmo_outputs", 8'h01, 8'h02, 6'h04, 1'b0);
        strobe(8'h07);
        strobe(8'h08);
        strobe(8'h01);
        check_out("tmo_refill", 8'h07, 8'h08, 6'h01, 1'b1);

        // Strobe lands exactly in the expiry cycle and must be accepted.
        tmo_base = n_tmo;
        strobe(8'h0C);
        idle(15);
        strobe(8'h0D);
        idle(15);
        strobe(8'h0E);
        check_out("expiry_strobe", 8'h0C, 8'h0D, 6'h0E, 1'b1);
        @(negedge clk);
        check("expiry_no_tmo", 32'(n_tmo - tmo_base), 32'd0);
`else
        // Without the timeout a partial frame waits indefinitely.
        tmo_base = n_tmo;
        strobe(8'h0A);
        idle(10000);
        strobe(8'h0B);
        strobe(8'h02);
        check_out("no_tmo_frame", 8'h0A, 8'h0B, 6'h02, 1'b1);
        @(negedge clk);
        check("no_tmo_pulses", 32'(n_tmo - tmo_base), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_operand_collector.md
# rx_operand_collector

Byte-to-operand assembler between the UART receiver and the ALU. It consumes each received byte when the receiver's one-cycle done strobe fires. It assembles three consecutive bytes into operand A, operand B and an opcode, then presents them to the ALU with a one-cycle completion pulse. Outputs hold the last complete frame, so the ALU always sees a stable, coherent operand set.

## Interface
- DBIT, 8, data bits per received byte; also the width of A and B
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte; must satisfy NB_OP ≤ DBIT
- TIMEOUT_CYC, 1000000, inter-byte timeout in i_clk cycles; used only when RX_TIMEOUT_EN is defined; must be ≥ 2
- i_clk  input  1  system clock; single clock domain
- i_rst  input  1  synchronous, active-high reset
- i_data  input  DBIT  received byte; valid only in cycles where i_done_data is high
- i_done_data  input  1  one-cycle strobe from the receiver; a byte is available
- o_a  output  DBIT  operand A of the last complete frame
- o_b  output  DBIT  operand B of the last complete frame
- o_op  output  NB_OP  opcode of the last complete frame
- o_rx_alu_done  output  1  one-cycle pulse; o_a/o_b/o_op were just updated
- o_timeout  output  1  one-cycle pulse; a partial frame was discarded (constant 0 without RX_TIMEOUT_EN)

## Operation
- States: S_A (wait first byte), S_B (wait second), S_OP (wait third).
- Reset state is S_A.
- S_A, on i_done_data: stage A ← i_data; go to S_B.
- S_B, on i_done_data: stage B ← i_data; go to S_OP.
- S_OP, on i_done_data, all at the same edge: o_a ← staged A; o_b ← staged B; o_op ← i_data[NB_OP-1:0]; o_rx_alu_done ← 1; go to S_A.
- i_data[DBIT-1:NB_OP] is ignored on the opcode byte.
- Staging registers are internal. o_a/o_b/o_op change only at frame completion; they never expose a partial frame.
- With i_done_data low, the state and all registers hold (except the timeout counter).
- i_data is not sampled when i_done_data is low.
- No backpressure: every strobe is consumed. The downstream ALU must accept o_rx_alu_done unconditionally.
- Reset (any state, including mid-frame) has the following effect:
  - state → S_A
  - staging registers → 0
  - o_a, o_b, o_op → 0
  - o_rx_alu_done, o_timeout → 0
  - timeout counter → 0
  - any partial frame is dropped

## Timing
- Latency: i_done_data sampled high on the op byte at edge N → o_rx_alu_done high for exactly the cycle after edge N, with new o_a/o_b/o_op valid in that same cycle.
- o_rx_alu_done deasserts at edge N+1 unless a new frame completes there. That cannot happen, since a frame needs three strobes.
- Back-to-back strobes on consecutive cycles are accepted; a full frame can complete 2 cycles after its first byte.
- i_rst is sampled at the clock edge and has priority over i_done_data in the same cycle.

## Configuration
- Macro: RX_TIMEOUT_EN.
- Defined, counter behaviour:
  - In S_B or S_OP, a counter increments each cycle with no strobe.
  - The counter clears on every accepted byte and whenever in S_A.
  - When the counter reaches TIMEOUT_CYC-1 in a cycle without a strobe: go to S_A, clear staging registers, pulse o_timeout for the next cycle, leave o_a/o_b/o_op unchanged.
- Defined, simultaneous events: a strobe in the expiry cycle wins; the byte is accepted and no timeout fires.
- Not defined: no counter is synthesized; o_timeout is tied to 0; a partial frame waits indefinitely.

## Test plan
Scenarios use DBIT=8, NB_OP=6.
- Reset: hold i_rst 2 cycles → all outputs 0, state S_A.
- Basic frame: strobes with 0x05, 0x03, 0x20 spaced 10 cycles apart → one cycle after the third strobe, o_a=0x05, o_b=0x03, o_op=0x20, o_rx_alu_done high for exactly 1 cycle.
- Opcode truncation, back-to-back: strobes on 3 consecutive cycles with 0xFF, 0x80, 0xE6 → o_a=0xFF, o_b=0x80, o_op=0x26, single done pulse.
- Output hold and mid-frame reset:
  - Complete frame 0x11/0x22/0x03, then send 0xAA, 0xBB → o_a/o_b/o_op stay 0x11/0x22/0x03 and no done pulse.
  - Assert i_rst, then send 0x01/0x02/0x04 → exactly one done pulse with 0x01/0x02/0x04.
- Timeout (RX_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Send 0x0A, then idle 20 cycles → o_timeout pulses once; outputs unchanged.
  - Then send 0x07/0x08/0x01 → o_a=0x07, o_b=0x08, o_op=0x01.
  - Put a strobe in the expiry cycle → byte accepted, no o_timeout.
- No timeout (macro undefined): send 0x0A, idle 10000 cycles, then send 0x0B, 0x02 → frame completes with o_a=0x0A, o_b=0x0B, o_op=0x02; o_timeout never high.
